// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-requester ALU arbiter: datapath widths,
// requester count, ALU opcode constants and the arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int DATA_W  = 32;
   localparam int OP_W    = 5;
   localparam int SHAMT_W = 5;
   localparam int NUM_REQ = 2;

   // Opcodes understood by the shared ALU; anything else is passed through
   // untouched and the ALU applies its own default behaviour.
   localparam logic [OP_W-1:0] OP_ADD = 5'd0;
   localparam logic [OP_W-1:0] OP_SUB = 5'd1;
   localparam logic [OP_W-1:0] OP_AND = 5'd2;
   localparam logic [OP_W-1:0] OP_OR  = 5'd3;
   localparam logic [OP_W-1:0] OP_SLL = 5'd4;
   localparam logic [OP_W-1:0] OP_SRA = 5'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/alu_arb_grant.sv
// -----------------------------------------------------------------------------
// alu_arb_grant
// One-hot grant selection between the two requesters. A grant is only issued
// while the arbiter is idle. A lone valid requester always wins; on a tie the
// winner is chosen by the configured policy.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   -> round-robin: the tie goes to the requester that did not
//                win the previous transfer (last_grant).
//   undefined -> fixed priority: requester 0 wins every tie; last_grant is
//                ignored.
//
// Ports:
//   valid      in  [NUM_REQ-1:0]  request valids {req1, req0}
//   last_grant in  1              index of the most recently accepted requester
//   idle       in  1              arbiter FSM is in IDLE
//   grant      out [NUM_REQ-1:0]  one-hot grant (all zero when nothing granted)
// -----------------------------------------------------------------------------
module alu_arb_grant
   import alu_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic               last_grant,
   input  logic               idle,
   output logic [NUM_REQ-1:0] grant
);

   logic [NUM_REQ-1:0] tie_grant_s;

`ifdef ALU_ARB_RR_EN
   assign tie_grant_s = last_grant ? 2'b01 : 2'b10;
`else
   logic unused_last_grant_s;
   assign unused_last_grant_s = last_grant;
   assign tie_grant_s = 2'b01;
`endif

   // Grant decode: single requester wins outright, contention uses the tie winner.
   always_comb begin
      grant = 2'b00;
      if (idle) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = tie_grant_s;
            default: grant = 2'b00;
         endcase
      end else begin
         grant = 2'b00;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. Each operation runs
// IDLE -> EXEC -> RESP: the granted request is latched into the ALU drive
// registers, the ALU outputs are captured one edge later, and the response is
// held on the response bus until the consumer takes it.
//
// Configuration macro: ALU_ARB_RR_EN (round-robin arbitration when defined,
// fixed priority to requester 0 otherwise; see alu_arb_grant).
//
// Ports:
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   reqN_valid/ready                request handshake for requester N (0,1)
//   reqN_opcode/shamt/operandA/B    request payload
//   alu_opcode/shamt/operandA/B     registered drive to the shared ALU
//   alu_result/isNotEqual/          ALU outputs, captured in EXEC
//     isLessThan/overflow
//   rsp_valid/ready                 response handshake
//   rsp_id                          index of the requester that issued the op
//   rsp_result/isNotEqual/          captured ALU outputs
//     isLessThan/overflow
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_arb_pkg::*;
(
   input  logic               clock,
   input  logic               reset,

   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [OP_W-1:0]    req0_opcode,
   input  logic [SHAMT_W-1:0] req0_shamt,
   input  logic [DATA_W-1:0]  req0_operandA,
   input  logic [DATA_W-1:0]  req0_operandB,

   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [OP_W-1:0]    req1_opcode,
   input  logic [SHAMT_W-1:0] req1_shamt,
   input  logic [DATA_W-1:0]  req1_operandA,
   input  logic [DATA_W-1:0]  req1_operandB,

   output logic [OP_W-1:0]    alu_opcode,
   output logic [SHAMT_W-1:0] alu_shamt,
   output logic [DATA_W-1:0]  alu_operandA,
   output logic [DATA_W-1:0]  alu_operandB,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               alu_isNotEqual,
   input  logic               alu_isLessThan,
   input  logic               alu_overflow,

   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [DATA_W-1:0]  rsp_result,
   output logic               rsp_isNotEqual,
   output logic               rsp_isLessThan,
   output logic               rsp_overflow
);

   arb_state_e         state_r;
   logic [NUM_REQ-1:0] valid_s;
   logic [NUM_REQ-1:0] grant_s;
   logic               idle_s;
   logic               accept_s;
   logic               last_grant_s;

   logic [OP_W-1:0]    sel_opcode_s;
   logic [SHAMT_W-1:0] sel_shamt_s;
   logic [DATA_W-1:0]  sel_a_s;
   logic [DATA_W-1:0]  sel_b_s;
   logic               sel_id_s;

   logic [OP_W-1:0]    opcode_r;
   logic [SHAMT_W-1:0] shamt_r;
   logic [DATA_W-1:0]  a_r;
   logic [DATA_W-1:0]  b_r;
   logic               id_r;

   logic               rsp_valid_r;
   logic [DATA_W-1:0]  rsp_result_r;
   logic               rsp_ne_r;
   logic               rsp_lt_r;
   logic               rsp_ovf_r;

   assign valid_s  = {req1_valid, req0_valid};
   assign idle_s   = (state_r == ST_IDLE);

   alu_arb_grant u_grant (
      .valid      (valid_s),
      .last_grant (last_grant_s),
      .idle       (idle_s),
      .grant      (grant_s)
   );

   // Ready is the grant itself, so it can only be high in IDLE and one-hot.
   assign req0_ready = grant_s[0];
   assign req1_ready = grant_s[1];
   assign accept_s   = |(grant_s & valid_s);
   assign sel_id_s   = grant_s[1];

`ifdef ALU_ARB_RR_EN
   logic last_grant_r;

   // Last-grant pointer: remembers the winner of each accepted transfer.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_r <= 1'b1;
      end else if (accept_s) begin
         last_grant_r <= sel_id_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   assign last_grant_s = last_grant_r;
`else
   assign last_grant_s = 1'b1;
`endif

   // Payload mux: forward the granted requester's fields to the input registers.
   always_comb begin
      if (grant_s[1]) begin
         sel_opcode_s = req1_opcode;
         sel_shamt_s  = req1_shamt;
         sel_a_s      = req1_operandA;
         sel_b_s      = req1_operandB;
      end else begin
         sel_opcode_s = req0_opcode;
         sel_shamt_s  = req0_shamt;
         sel_a_s      = req0_operandA;
         sel_b_s      = req0_operandB;
      end
   end

   // Arbiter FSM: latch on transfer, capture ALU outputs, hold response until taken.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         opcode_r     <= {OP_W{1'b0}};
         shamt_r      <= {SHAMT_W{1'b0}};
         a_r          <= {DATA_W{1'b0}};
         b_r          <= {DATA_W{1'b0}};
         id_r         <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_result_r <= {DATA_W{1'b0}};
         rsp_ne_r     <= 1'b0;
         rsp_lt_r     <= 1'b0;
         rsp_ovf_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  opcode_r <= sel_opcode_s;
                  shamt_r  <= sel_shamt_s;
                  a_r      <= sel_a_s;
                  b_r      <= sel_b_s;
                  id_r     <= sel_id_s;
                  state_r  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_result_r <= alu_result;
               rsp_ne_r     <= alu_isNotEqual;
               rsp_lt_r     <= alu_isLessThan;
               rsp_ovf_r    <= alu_overflow;
               rsp_valid_r  <= 1'b1;
               state_r      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   // The ALU is driven straight from the input registers so it holds between ops.
   assign alu_opcode     = opcode_r;
   assign alu_shamt      = shamt_r;
   assign alu_operandA   = a_r;
   assign alu_operandB   = b_r;

   // id_r only changes on acceptance, so it is stable for the whole RESP phase.
   assign rsp_valid      = rsp_valid_r;
   assign rsp_id         = id_r;
   assign rsp_result     = rsp_result_r;
   assign rsp_isNotEqual = rsp_ne_r;
   assign rsp_isLessThan = rsp_lt_r;
   assign rsp_overflow   = rsp_ovf_r;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
module tb_alu_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_opcode, req0_shamt, req1_opcode, req1_shamt;
   logic [31:0] req0_operandA, req0_operandB, req1_operandA, req1_operandB;
   logic [4:0]  alu_opcode, alu_shamt;
   logic [31:0] alu_operandA, alu_operandB, alu_result;
   logic        alu_isNotEqual, alu_isLessThan, alu_overflow;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_isNotEqual, rsp_isLessThan, rsp_overflow;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   always #5 clock = ~clock;

   alu_arbiter dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_shamt(req0_shamt), .req0_operandA(req0_operandA), .req0_operandB(req0_operandB),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_shamt(req1_shamt), .req1_operandA(req1_operandA), .req1_operandB(req1_operandB),
      .alu_opcode(alu_opcode), .alu_shamt(alu_shamt), .alu_operandA(alu_operandA),
      .alu_operandB(alu_operandB), .alu_result(alu_result), .alu_isNotEqual(alu_isNotEqual),
      .alu_isLessThan(alu_isLessThan), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_isNotEqual(rsp_isNotEqual), .rsp_isLessThan(rsp_isLessThan), .rsp_overflow(rsp_overflow)
   );

   // Shared ALU seen by the arbiter: {overflow, isLessThan, isNotEqual, result}.
   function automatic logic [34:0] alu_model(input logic [4:0] op, input logic [4:0] sh,
                                             input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        ovf;
      ovf = 1'b0;
      case (op)
         5'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
         5'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
         5'd2: r = a & b;
         5'd3: r = a | b;
         5'd4: r = a << sh;
         5'd5: r = $signed(a) >>> sh;
         default: r = a + b;
      endcase
      return {ovf, ($signed(a) < $signed(b)), (a != b), r};
   endfunction

   assign {alu_overflow, alu_isLessThan, alu_isNotEqual, alu_result} =
      alu_model(alu_opcode, alu_shamt, alu_operandA, alu_operandB);

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model + per-cycle compare -------------
   bit          pend = 1'b0;      // one operation accepted and not yet returned
   bit          seen = 1'b0;      // its response has already been shown
   bit          post_rst = 1'b0;
   bit          ptr = 1'b1;       // requester that won the last transfer
   int          cyc = 0;
   int          acc_cyc = 0;
   logic        p_id;
   logic [4:0]  p_op, p_sh;
   logic [31:0] p_a, p_b;
   logic [34:0] p_exp;
   logic [1:0]  exp_g;

   // Compare DUT outputs with the model on the falling edge of every cycle.
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         pend = 1'b0; ptr = 1'b1; post_rst = 1'b1;
      end else begin
         if (post_rst) begin
            check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check_eq("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
            check_eq("rst_rsp_result", rsp_result, 32'd0);
            check_eq("rst_rsp_flags", {29'd0, rsp_overflow, rsp_isLessThan, rsp_isNotEqual}, 32'd0);
            check_eq("rst_alu_ctl", {22'd0, alu_opcode, alu_shamt}, 32'd0);
            check_eq("rst_alu_a", alu_operandA, 32'd0);
            check_eq("rst_alu_b", alu_operandB, 32'd0);
            post_rst = 1'b0;
         end
         check_eq("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
         if (pend) begin
            check_eq("ready_busy", {30'd0, req1_ready, req0_ready}, 32'd0);
            check_eq("alu_ctl", {22'd0, alu_opcode, alu_shamt}, {22'd0, p_op, p_sh});
            check_eq("alu_a", alu_operandA, p_a);
            check_eq("alu_b", alu_operandB, p_b);
         end else begin
            if (req0_valid && req1_valid) exp_g = (RR && !ptr) ? 2'b10 : 2'b01;
            else exp_g = {req1_valid, req0_valid};
            check_eq("grant", {30'd0, req1_ready, req0_ready}, {30'd0, exp_g});
         end
         if (rsp_valid) begin
            if (!pend) begin
               check_eq("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
               if (!seen) check_eq("rsp_latency", cyc - acc_cyc, 32'd2);
               seen = 1'b1;
               check_eq("rsp_id", {31'd0, rsp_id}, {31'd0, p_id});
               check_eq("rsp_result", rsp_result, p_exp[31:0]);
               check_eq("rsp_flags", {29'd0, rsp_overflow, rsp_isLessThan, rsp_isNotEqual},
                        {29'd0, p_exp[34:32]});
               if (rsp_ready) pend = 1'b0;
            end
         end else if (pend) begin
            check_eq("rsp_late", {31'd0, (cyc - acc_cyc) < 2}, 32'd1);
         end
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            p_id = req1_valid && req1_ready;
            p_op = p_id ? req1_opcode   : req0_opcode;
            p_sh = p_id ? req1_shamt    : req0_shamt;
            p_a  = p_id ? req1_operandA : req0_operandA;
            p_b  = p_id ? req1_operandB : req0_operandB;
            p_exp = alu_model(p_op, p_sh, p_a, p_b);
            pend = 1'b1; seen = 1'b0; acc_cyc = cyc; ptr = p_id;
         end
      end
   end

   // ---------------- stimulus -------------------------------------------------
   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic set_req(input int n, input logic [4:0] op, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b);
      if (n == 0) begin
         req0_valid = 1'b1; req0_opcode = op; req0_shamt = sh; req0_operandA = a; req0_operandB = b;
      end else begin
         req1_valid = 1'b1; req1_opcode = op; req1_shamt = sh; req1_operandA = a; req1_operandB = b;
      end
   endtask

   task automatic wait_accept(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         ok = !reset && ((n == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready));
      end
      check_eq("accept_timeout", {31'd0, ok}, 32'd1);
      tick();
      if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      bit ok;
      ok = 1'b0; lat = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         lat++;
         ok = rsp_valid;
      end
      check_eq("rsp_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int  lat;
      int  order [4];
      bit  a0, a1;
      bit  got;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      req0_opcode = 5'd0; req0_shamt = 5'd0; req0_operandA = 32'd0; req0_operandB = 32'd0;
      req1_opcode = 5'd0; req1_shamt = 5'd0; req1_operandA = 32'd0; req1_operandB = 32'd0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Single request: ADD 5+7.
      rsp_ready = 1'b1;
      set_req(0, 5'd0, 5'd0, 32'd5, 32'd7);
      wait_accept(0);
      wait_rsp(lat);
      check_eq("single_latency", lat, 32'd2);
      check_eq("single_id", {31'd0, rsp_id}, 32'd0);
      check_eq("single_result", rsp_result, 32'd12);
      check_eq("single_ovf", {31'd0, rsp_overflow}, 32'd0);
      tick();

      // Contention with both requesters held valid, fresh pointer.
      do_reset();
      set_req(0, 5'd0, 5'd0, 32'd1, 32'd2);
      set_req(1, 5'd0, 5'd0, 32'd3, 32'd4);
      for (int g = 0; g < 4; g++) begin
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = req0_ready || req1_ready;
         end
         check_eq("contention_timeout", {31'd0, got}, 32'd1);
         order[g] = req1_ready ? 1 : 0;
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check_eq("grant_order0", order[0], 32'd0);
      check_eq("grant_order1", order[1], RR ? 32'd1 : 32'd0);
      check_eq("grant_order2", order[2], 32'd0);
      check_eq("grant_order3", order[3], RR ? 32'd1 : 32'd0);
      repeat (4) tick();

      // Backpressure: SUB 3-8 held while rsp_ready is low, req0 waiting.
      rsp_ready = 1'b0;
      set_req(1, 5'd1, 5'd0, 32'd3, 32'd8);
      wait_accept(1);
      set_req(0, 5'd0, 5'd0, 32'd1, 32'd1);
      wait_rsp(lat);
      for (int i = 0; i < 4; i++) begin
         check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
         check_eq("bp_id", {31'd0, rsp_id}, 32'd1);
         check_eq("bp_result", rsp_result, 32'hFFFF_FFFB);
         check_eq("bp_lt", {31'd0, rsp_isLessThan}, 32'd1);
         check_eq("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
         @(negedge clock);
      end
      tick();
      rsp_ready = 1'b1;
      wait_accept(0);
      wait_rsp(lat);
      check_eq("bp_followup_result", rsp_result, 32'd2);
      tick();

      // Reset while the operation is in EXEC drops it.
      set_req(0, 5'd0, 5'd0, 32'd9, 32'd9);
      wait_accept(0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check_eq("dropped_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      tick();
      set_req(1, 5'd3, 5'd0, 32'h0000_00F0, 32'h0000_000F);
      @(negedge clock);
      check_eq("idle_after_reset", {31'd0, req1_ready}, 32'd1);
      wait_accept(1);
      wait_rsp(lat);
      check_eq("or_result", rsp_result, 32'h0000_00FF);
      tick();

      // Pass-through: SRA and an undefined opcode.
      set_req(0, 5'd5, 5'd4, 32'h8000_0000, 32'd0);
      wait_accept(0);
      wait_rsp(lat);
      check_eq("sra_result", rsp_result, 32'hF800_0000);
      tick();
      set_req(0, 5'd9, 5'd0, 32'd10, 32'd20);
      wait_accept(0);
      wait_rsp(lat);
      check_eq("op9_alu_opcode", {27'd0, alu_opcode}, 32'd9);
      check_eq("op9_result", rsp_result, 32'd30);
      tick();

      // Randomized traffic with requesters holding payload until accepted.
      for (int c = 0; c < 600; c++) begin
         @(negedge clock);
         a0 = !reset && req0_valid && req0_ready;
         a1 = !reset && req1_valid && req1_ready;
         tick();
         reset = (c == 300);
         if (!req0_valid || a0) begin
            if ($urandom_range(0, 1) == 1)
               set_req(0, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5)),
                       5'($urandom), $urandom, ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom);
            else
               req0_valid = 1'b0;
         end
         if (!req1_valid || a1) begin
            if ($urandom_range(0, 1) == 1)
               set_req(1, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5)),
                       5'($urandom), ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom, $urandom);
            else
               req1_valid = 1'b0;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
